timer_dev: RTL and testbench

Memory-mapped countdown timer on the data-side bus, downstream of the pipelined CPU core. It receives the core's store address, store data, write enable and byte enables through the system bridge, and returns read data for loads. It drives one interrupt line back into the core's interrupt-request vector. It supports two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

---
 rtl/timer_dev.sv | 148 ++++++++++++++
 tb/tb_timer_dev.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers.
// It runs one-shot (held interrupt) or auto-reload (one-cycle interrupt pulse).
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

    localparam logic [1:0] A_CTRL      = 2'd0;
    localparam logic [1:0] A_PRESET    = 2'd1;
    localparam logic [1:0] A_COUNT     = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'd1;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic ctrl_wr, preset_wr, auto_reload, count_le1;
    logic do_load, do_dec, do_expire, do_clr_en, do_clr_flag;
    logic unused_addr;

    assign ctrl_wr     = sel & we & (addr[3:2] == A_CTRL);
    assign preset_wr   = sel & we & (addr[3:2] == A_PRESET);
    assign auto_reload = (mode_q == MODE_RELOAD);
    assign count_le1   = (count_q <= 32'd1);
    assign unused_addr = ^addr[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_q) state_d = S_LOAD;
            S_LOAD:  state_d = S_CNT;
            S_CNT: begin
                if (!en_q)          state_d = S_IDLE;
                else if (count_le1) state_d = S_INT;
            end
            S_INT:   state_d = auto_reload ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        do_load     = 1'b0;
        do_dec      = 1'b0;
        do_expire   = 1'b0;
        do_clr_en   = 1'b0;
        do_clr_flag = 1'b0;
        case (state_q)
            S_LOAD: do_load = 1'b1;
            S_CNT: begin
                if (en_q) begin
                    if (count_le1) do_expire = 1'b1;
                    else           do_dec    = 1'b1;
                end
            end
            S_INT: begin
                if (auto_reload) do_clr_flag = 1'b1;
                else             do_clr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // CPU writes are applied after FSM effects so they win on the same edge.
    always_comb begin
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (do_clr_en) en_d = 1'b0;
        if (ctrl_wr && byteen[0]) begin
            en_d   = wdata[0];
            mode_d = wdata[2:1];
            im_d   = wdata[3];
        end

        if (preset_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        if (do_load)        count_d = preset_q;
        else if (do_dec)    count_d = count_q - 32'd1;
        else if (do_expire) count_d = '0;

        if (do_expire)        irq_flag_d = 1'b1;
        else if (do_clr_flag) irq_flag_d = 1'b0;
        if (ctrl_wr || preset_wr) irq_flag_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            A_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
            A_PRESET: rdata = preset_q;
            A_COUNT:  rdata = count_q;
            default:  rdata = '0;
        endcase
    end

    assign irq = irq_flag_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: inputs change and outputs are sampled on the
// falling edge, so "after edge E" means the negedge that follows E.
module tb_timer_dev;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    timer_dev dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 4'h0;
        byteen = 4'h0;
        wdata  = 32'h0;
    endtask

    // One store, committed on the next rising edge; returns at the following negedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        sel    = 1'b1;
        we     = 1'b1;
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus_idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] r;
        logic [3:0]  a;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r = $urandom; sel = r[0]; we = r[1]; byteen = r[7:4];
            r = $urandom; addr = r[3:0];
            wdata = $urandom;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            a = 4'(4 * i);
            read_reg(a, d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_rdata[addr %0d]: got %h expected 00000000", a, d);
            end
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (irq !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle_irq[%0d]: got %b expected 0", i, irq);
            end
        end
        for (int i = 0; i < 3; i++) begin
            a = 4'(4 * i);
            read_reg(a, d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_idle_rdata[addr %0d]: got %h expected 00000000", a, d);
            end
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        do_reset();
        bus_write(4'h4, 32'd5, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            read_reg(4'h8, d);
            vectors++;
            if (d !== 32'(5 - k) || irq !== 1'b0) begin
                miscompares++;
                $display("FAIL oneshot_count[%0d]: count=%0d irq=%b expected count=%0d irq=0", k, d, irq, 5 - k);
            end
        end
        @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (irq !== 1'b1 || d !== 32'd0) begin
            miscompares++;
            $display("FAIL oneshot_irq_rise: irq=%b count=%0d expected irq=1 count=0", irq, d);
        end
        @(negedge clk);
        @(negedge clk);
        read_reg(4'h0, d);
        vectors++;
        if (d !== 32'h8 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_held: ctrl=%h irq=%b expected ctrl=8 irq=1", d, irq);
        end
        bus_write(4'h0, 32'h8, 4'hF);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_clear: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic exp;
        do_reset();
        bus_write(4'h4, 32'd3, 4'hF);
        bus_write(4'h0, 32'hB, 4'hF);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            exp = (c % 5 == 0);
            vectors++;
            if (irq !== exp) begin
                miscompares++;
                $display("FAIL reload_irq[cycle %0d]: got %b expected %b", c, irq, exp);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        do_reset();
        bus_write(4'h4, 32'hAABB_CCDD, 4'hF);
        sel = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'h1122_3344; byteen = 4'b0101;
        #1;
        vectors++;
        if (rdata !== 32'hAABB_CCDD) begin
            miscompares++;
            $display("FAIL read_during_write: got %h expected aabbccdd", rdata);
        end
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        read_reg(4'h4, d);
        vectors++;
        if (d !== 32'hAA22_CC44) begin
            miscompares++;
            $display("FAIL preset_lanes: got %h expected aa22cc44", d);
        end
        bus_write(4'h8, 32'hFFFF_FFFF, 4'hF);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL count_write_ignored: got %h expected 00000000", d);
        end
        bus_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        read_reg(4'hC, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL addr3_reads_zero: got %h expected 00000000", d);
        end
        bus_write(4'h0, 32'hFFFF_FFF0, 4'hF);
        read_reg(4'h0, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL ctrl_reserved_bits: got %h expected 00000000", d);
        end
        bus_write(4'h0, 32'hFFFF_FFFF, 4'b1110);
        read_reg(4'h0, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("FAIL ctrl_lane0_disabled: got %h expected 00000000", d);
        end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        do_reset();
        bus_write(4'h4, 32'd10, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        @(negedge clk);
        @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd10) begin
            miscompares++;
            $display("FAIL disable_start: count=%0d expected 10", d);
        end
        repeat (4) @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd6) begin
            miscompares++;
            $display("FAIL disable_at6: count=%0d expected 6", d);
        end
        bus_write(4'h0, 32'h8, 4'hF);
        for (int i = 0; i < 10; i++) begin
            read_reg(4'h8, d);
            vectors++;
            if (d !== 32'd5 || irq !== 1'b0) begin
                miscompares++;
                $display("FAIL disable_frozen[%0d]: count=%0d irq=%b expected count=5 irq=0", i, d, irq);
            end
            @(negedge clk);
        end
        bus_write(4'h0, 32'h9, 4'hF);
        @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd5) begin
            miscompares++;
            $display("FAIL reenable_load_cycle: count=%0d expected 5", d);
        end
        @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd10) begin
            miscompares++;
            $display("FAIL reenable_reload: count=%0d expected 10", d);
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] d;
        logic exp;
        // PRESET=0: interrupt three edges after enable
        do_reset();
        bus_write(4'h4, 32'd0, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            exp = (c == 3);
            vectors++;
            if (irq !== exp) begin
                miscompares++;
                $display("FAIL preset0_irq[cycle %0d]: got %b expected %b", c, irq, exp);
            end
        end
        // MODE=2 behaves as one-shot
        do_reset();
        bus_write(4'h4, 32'd1, 4'hF);
        bus_write(4'h0, 32'hD, 4'hF);
        repeat (5) @(negedge clk);
        read_reg(4'h0, d);
        vectors++;
        if (irq !== 1'b1 || d !== 32'hC) begin
            miscompares++;
            $display("FAIL mode2_oneshot: irq=%b ctrl=%h expected irq=1 ctrl=c", irq, d);
        end
        // PRESET rewritten to 2 mid-period in auto-reload
        do_reset();
        bus_write(4'h4, 32'd3, 4'hF);
        bus_write(4'h0, 32'hB, 4'hF);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 3) bus_idle();
            exp = (c == 5) || (c == 9) || (c == 13);
            vectors++;
            if (irq !== exp) begin
                miscompares++;
                $display("FAIL preset_change_irq[cycle %0d]: got %b expected %b", c, irq, exp);
            end
            if (c == 7) begin
                read_reg(4'h8, d);
                vectors++;
                if (d !== 32'd2) begin
                    miscompares++;
                    $display("FAIL preset_change_reload: count=%0d expected 2", d);
                end
            end
            if (c == 2) begin
                sel = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'd2; byteen = 4'hF;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        bus_write(4'h4, 32'd1, 4'hF);
        bus_write(4'h0, 32'h9, 4'hF);
        @(negedge clk);
        @(negedge clk);
        read_reg(4'h8, d);
        vectors++;
        if (d !== 32'd1) begin
            miscompares++;
            $display("FAIL b2b_count1: count=%0d expected 1", d);
        end
        bus_write(4'h4, 32'd1, 4'hF);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_write_beats_set: irq=%b expected 0", irq);
        end
        bus_write(4'h0, 32'h9, 4'hF);
        read_reg(4'h0, d);
        vectors++;
        if (d !== 32'h9) begin
            miscompares++;
            $display("FAIL b2b_write_beats_en_clear: ctrl=%h expected 9", d);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart_irq: irq=%b expected 1", irq);
        end
    endtask

    initial begin
        bus_idle();
        reset = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_byte_lanes();
        test_disable();
        test_edge_cases();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
